// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the multiplexed 7-segment bus and the decoded result for
// seg7_scan_decoder.
//   SegIn    [0:6]      segment lines a..g, SegIn[0] = a
//   DigSel   [NDIG-1:0] one-hot digit select, active-high
//   CcCa                segment polarity: 0 = common cathode, 1 = common anode
//   ErrClr              clears the sticky SegErr flag
//   BinOut   [4*NDIG-1:0] decoded nibble per digit, digit i in [4i+3:4i]
//   DigValid [NDIG-1:0] digit i currently holds a valid hex glyph
//   ValStb / ErrStb     one-cycle commit strobes (valid glyph / invalid pattern)
//   DigIdx   [2:0]      digit index of the last strobe
//   SegErr              sticky invalid-pattern flag
// master: the side that drives the display bus. slave: the decoder.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int NDIG = 4
);
    logic [0:6]        SegIn;
    logic [NDIG-1:0]   DigSel;
    logic              CcCa;
    logic              ErrClr;
    logic [4*NDIG-1:0] BinOut;
    logic [NDIG-1:0]   DigValid;
    logic              ValStb;
    logic [2:0]        DigIdx;
    logic              ErrStb;
    logic              SegErr;

    modport master (
        output SegIn, DigSel, CcCa, ErrClr,
        input  BinOut, DigValid, ValStb, DigIdx, ErrStb, SegErr
    );

    modport slave (
        input  SegIn, DigSel, CcCa, ErrClr,
        output BinOut, DigValid, ValStb, DigIdx, ErrStb, SegErr
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Receive side of a multiplexed 7-segment display bus. Registers the segment
// lines, digit select and polarity, normalises the pattern to "1 = segment on",
// waits for STABLE_CYC identical scannable samples and then commits the glyph
// to the selected digit exactly once per stable episode.
//   Clk  rising-edge clock
//   Rst  synchronous active-high reset
//   bus  seg7_scan_decoder_if.slave (segment inputs, decoded outputs)
// Parameters: NDIG digits (1..8), STABLE_CYC samples to commit (>= 2).
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    seg7_scan_decoder_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int S_W   = NDIG + 7;

    // Stage-1 sample registers
    logic [0:6]        seg_r_q, seg_r_d;
    logic [NDIG-1:0]   sel_r_q, sel_r_d;
    logic              pol_r_q, pol_r_d;
    // Stability tracking
    logic [S_W-1:0]    prev_s_q, prev_s_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Registered outputs
    logic [4*NDIG-1:0] bin_q, bin_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              val_stb_q, val_stb_d;
    logic              err_stb_q, err_stb_d;
    logic [2:0]        dig_idx_q, dig_idx_d;
    logic              seg_err_q, seg_err_d;

    // Glyph lookup in abcdefg order: returns {hit, value}.
    function automatic logic [4:0] decode(input logic [0:6] n);
        logic [4:0] r;
        case (n)
            7'b1111110: r = {1'b1, 4'h0};
            7'b0110000: r = {1'b1, 4'h1};
            7'b1101101: r = {1'b1, 4'h2};
            7'b1111001: r = {1'b1, 4'h3};
            7'b0110011: r = {1'b1, 4'h4};
            7'b1011011: r = {1'b1, 4'h5};
            7'b1011111: r = {1'b1, 4'h6};
            7'b1110000: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1111011: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b0011111: r = {1'b1, 4'hB};
            7'b1001110: r = {1'b1, 4'hC};
            7'b0111101: r = {1'b1, 4'hD};
            7'b1001111: r = {1'b1, 4'hE};
            7'b1000111: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    logic [0:6]     n_w;
    logic [S_W-1:0] s_w;
    logic           scannable;
    logic           same;
    logic           commit;
    logic [4:0]     dec_w;
    logic           blank;
    logic [2:0]     sel_idx;

    // Polarity is folded in before comparison so a CcCa toggle looks like a
    // pattern change and restarts the stability count.
    assign n_w       = pol_r_q ? ~seg_r_q : seg_r_q;
    assign s_w       = {sel_r_q, n_w};
    assign scannable = $onehot(sel_r_q);
    assign same      = (s_w == prev_s_q);
    // Fires on the single sample where the count crosses STABLE_CYC-1; the
    // counter then saturates, so a held pattern never commits twice.
    assign commit    = scannable && same && (cnt_q == CNT_W'(STABLE_CYC - 1));
    assign dec_w     = decode(n_w);
    assign blank     = (n_w == 7'b0000000);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel_r_q[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        // NOTE: every *_d starts from a default so no path can infer a latch.
        seg_r_d   = bus.SegIn;
        sel_r_d   = bus.DigSel;
        pol_r_d   = bus.CcCa;
        prev_s_d  = s_w;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        valid_d   = valid_q;
        val_stb_d = 1'b0;
        err_stb_d = 1'b0;
        dig_idx_d = dig_idx_q;
        seg_err_d = seg_err_q;

        if (!scannable)
            cnt_d = '0;
        else if (!same)
            cnt_d = CNT_W'(1);
        else if (cnt_q < CNT_W'(STABLE_CYC))
            cnt_d = cnt_q + CNT_W'(1);

        // Clear first so an invalid commit in the same cycle re-sets the flag.
        if (bus.ErrClr) seg_err_d = 1'b0;

        if (commit) begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel_r_q[i]) begin
                    if (dec_w[4]) begin
                        bin_d[4*i +: 4] = dec_w[3:0];
                        valid_d[i]      = 1'b1;
                    end else if (blank) begin
                        bin_d[4*i +: 4] = 4'h0;
                        valid_d[i]      = 1'b0;
                    end else begin
                        valid_d[i]      = 1'b0;   // nibble keeps its last value
                    end
                end
            end
            if (dec_w[4]) begin
                val_stb_d = 1'b1;
                dig_idx_d = sel_idx;
            end else if (!blank) begin
                err_stb_d = 1'b1;
                dig_idx_d = sel_idx;
                seg_err_d = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            seg_r_q   <= '0;
            sel_r_q   <= '0;
            pol_r_q   <= 1'b0;
            prev_s_q  <= '0;
            cnt_q     <= '0;
            bin_q     <= '0;
            valid_q   <= '0;
            val_stb_q <= 1'b0;
            err_stb_q <= 1'b0;
            dig_idx_q <= '0;
            seg_err_q <= 1'b0;
        end else begin
            seg_r_q   <= seg_r_d;
            sel_r_q   <= sel_r_d;
            pol_r_q   <= pol_r_d;
            prev_s_q  <= prev_s_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            valid_q   <= valid_d;
            val_stb_q <= val_stb_d;
            err_stb_q <= err_stb_d;
            dig_idx_q <= dig_idx_d;
            seg_err_q <= seg_err_d;
        end
    end

    assign bus.BinOut   = bin_q;
    assign bus.DigValid = valid_q;
    assign bus.ValStb   = val_stb_q;
    assign bus.ErrStb   = err_stb_q;
    assign bus.DigIdx   = dig_idx_q;
    assign bus.SegErr   = seg_err_q;
endmodule
